// File: rtl/frame_pkg.sv
// Shared types and default sizing for the frame packer and its decimator.
package frame_pkg;

  localparam int unsigned N_CH_DEF      = 22;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned DECIM_W_DEF   = 16;
  localparam int unsigned FRAME_CNT_W   = 32;
  localparam int unsigned OVERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  // Word index must reach N_CH (header + N_CH channels).
  function automatic int unsigned idx_width(int unsigned n_ch);
    return $clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/sample_decimator.sv
// Counts sample strobes while enabled and flags every ratio-th one as a due capture.
module sample_decimator #(
  parameter int unsigned RATIO_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sample,
  input  logic [RATIO_W-1:0] ratio,
  output logic               due
);

  logic [RATIO_W-1:0] count;
  logic [RATIO_W:0]   count_inc;
  logic [RATIO_W:0]   ratio_eff;

  // Compare the incremented count so a lowered ratio fires on the very next pulse.
  always_comb begin
    ratio_eff = (ratio == '0) ? (RATIO_W+1)'(1) : {1'b0, ratio};
    count_inc = {1'b0, count} + (RATIO_W+1)'(1);
    due       = enable && sample && (count_inc >= ratio_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (sample) begin
      count <= due ? '0 : count_inc[RATIO_W-1:0];
    end
  end

endmodule

// File: rtl/frame_packer.sv
// Snapshots N_CH channel words on a decimated sample strobe and streams them
// out as one frame: a header holding the frame number, then channels 0..N_CH-1.
module frame_packer
  import frame_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DECIM_W = DECIM_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     sample_i,
  input  logic [DECIM_W-1:0]       decim_i,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  output logic [DATA_W-1:0]        m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_last_o,
  output logic [FRAME_CNT_W-1:0]   frame_cnt_o,
  output logic [OVERRUN_CNT_W-1:0] overrun_cnt_o,
  output logic                     busy_o
);

  localparam int unsigned IDX_W = idx_width(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] snap [N_CH];
  logic              due;
  logic              handshake;
  logic [IDX_W-1:0]  next_idx;
  logic [DATA_W-1:0] next_word;
  logic              next_last;

  sample_decimator #(
    .RATIO_W (DECIM_W)
  ) u_decim (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_i),
    .sample (sample_i),
    .ratio  (decim_i),
    .due    (due)
  );

  assign handshake = m_valid_o && m_ready_i;
  assign busy_o    = (state != IDLE);

  // Channel word to present after the current handshake.
  always_comb begin
    next_idx  = (state == HEADER) ? '0 : idx + IDX_W'(1);
    next_last = (next_idx == LAST_IDX);
    next_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (IDX_W'(i) == next_idx) next_word = snap[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      m_data_o      <= '0;
      m_valid_o     <= 1'b0;
      m_last_o      <= 1'b0;
      frame_cnt_o   <= '0;
      overrun_cnt_o <= '0;
      for (int i = 0; i < N_CH; i++) snap[i] <= '0;
    end else begin
      // Any capture outside IDLE, including the final-handshake cycle, is lost.
      if (due && (state != IDLE) && (overrun_cnt_o != '1)) begin
        overrun_cnt_o <= overrun_cnt_o + OVERRUN_CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (due) begin
            for (int i = 0; i < N_CH; i++) snap[i] <= ch_data_i[i*DATA_W +: DATA_W];
            frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
            m_data_o    <= DATA_W'(frame_cnt_o + FRAME_CNT_W'(1));
            m_valid_o   <= 1'b1;
            m_last_o    <= 1'b0;
            idx         <= '0;
            state       <= HEADER;
          end
        end
        HEADER: begin
          if (handshake) begin
            m_data_o <= next_word;
            m_last_o <= next_last;
            idx      <= next_idx;
            state    <= DATA;
          end
        end
        DATA: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              m_data_o  <= '0;
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              m_data_o <= next_word;
              m_last_o <= next_last;
              idx      <= next_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter N_CH, default 22, number of 32-bit channels packed per frame (1..64).
REQ-002 Parameter DATA_W, default 32, channel and output word width.
REQ-003 Parameter DECIM_W, default 16, width of decimation ratio input.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable_i  in  1  capture enable; low suppresses new captures, does not abort a frame in flight.
REQ-007 sample_i  in  1  one-cycle strobe marking a new set of valid channel values.
REQ-008 decim_i  in  DECIM_W  decimation ratio; 0 treated as 1.
REQ-009 ch_data_i  in  N_CH*DATA_W  flattened channels, channel 0 in LSBs.
REQ-010 m_data_o  out  DATA_W  stream word.
REQ-011 m_valid_o  out  1  stream word valid.
REQ-012 m_ready_i  in  1  downstream ready.
REQ-013 m_last_o  out  1  marks final word of frame.
REQ-014 frame_cnt_o  out  32  accepted-frame counter.
REQ-015 overrun_cnt_o  out  16  dropped-capture counter.
REQ-016 busy_o  out  1  high while state is not IDLE.

Function
REQ-017 Decimator SHALL count sample_i pulses while enable_i high; capture is due on pulse where count reaches max(decim_i,1), count then restarts at 0.
REQ-018 decim_i change SHALL take effect at next due comparison; if count already >= new ratio, next pulse is due.
REQ-019 enable_i low SHALL hold decimation count at 0.
REQ-020 On due capture in IDLE, all N_CH words SHALL be latched into snapshot register in that same cycle; ch_data_i thereafter ignored until next capture.
REQ-021 States: IDLE -> HEADER on capture; HEADER -> DATA on handshake; DATA -> IDLE on handshake of word N_CH-1; no other transitions except reset.
REQ-022 m_valid_o SHALL rise the cycle after capture (latency 1) and stay high until handshake (m_valid_o & m_ready_i).
REQ-023 m_data_o, m_last_o SHALL be stable while m_valid_o high and m_ready_i low.
REQ-024 HEADER word SHALL equal frame_cnt_o value post-increment (first frame header = 1).
REQ-025 DATA words SHALL be channel 0..N_CH-1 in order; m_last_o high only on channel N_CH-1.
REQ-026 frame_cnt_o SHALL increment by 1 on each capture, wrapping 0xFFFFFFFF -> 0.
REQ-027 Capture due while not IDLE SHALL be dropped and overrun_cnt_o incremented, saturating at 0xFFFF.
REQ-028 Capture due in the same cycle as final DATA handshake SHALL be dropped (counted as overrun); no back-to-back re-entry.
REQ-029 With m_ready_i held high, frame SHALL occupy exactly N_CH+1 consecutive valid cycles.
REQ-030 Word index counter SHALL be ceil(log2(N_CH+1)) bits.

Reset
REQ-031 rst asserted SHALL immediately force: state IDLE, m_valid_o 0, m_last_o 0, m_data_o 0, busy_o 0, frame_cnt_o 0, overrun_cnt_o 0, decimation count 0, snapshot 0.
REQ-032 rst mid-frame SHALL abandon the frame without emitting m_last_o; first post-reset frame header = 1.

Structure
REQ-033 Package frame_pkg SHALL hold state enum (IDLE, HEADER, DATA), default N_CH/DATA_W/DECIM_W constants and counter widths.
REQ-034 Decimator SHALL be a separate sub-module sample_decimator (clk, rst, enable, sample, ratio -> due).

Verification
REQ-035 N_CH=4, decim_i=1, ready high, one sample with ch={A,B,C,D} -> valid next cycle, words 1,A,B,C,D, last on D, frame_cnt_o=1.
REQ-036 decim_i=3, 9 samples -> exactly 3 frames, headers 1,2,3; decim_i=0 behaves as 1.
REQ-037 m_ready_i toggled 1010..., ch_data_i changed after capture -> words unchanged while stalled, snapshot values emitted.
REQ-038 Sample during frame in flight and sample coinciding with final handshake -> both dropped, overrun_cnt_o=2, no frame corruption.
REQ-039 rst pulsed during DATA word 2 -> outputs zero same cycle; next capture emits header 1 with full frame.
REQ-040 frame_cnt_o preloaded via force to 0xFFFFFFFF, one capture -> header 0, frame_cnt_o=0.
